traffic_light_controller_n: RTL and testbench

Parametrised N-direction intersection controller, successor to the fixed two-way, six-state controller. It serves one direction at a time through green, yellow and all-red phases, with per-phase durations set by parameters. It runs in fixed round-robin or demand-actuated mode and supports emergency preemption. It sits between the sensor/request synchroniser and the lamp driver block.

---
 rtl/traffic_light_controller_n.sv | 140 ++++++++++++++
 tb/tb_traffic_light_controller_n.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_controller_n.sv
// N-direction intersection controller: one direction at a time through green, yellow and
// all-red, in fixed round-robin or demand-actuated order, with emergency preemption.
module traffic_light_controller_n #(
  parameter int N_DIR    = 4,
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 15,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 3,
  localparam int DIR_W   = (N_DIR > 2) ? $clog2(N_DIR) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [N_DIR-1:0]   req,
  input  logic               preempt,
  input  logic [DIR_W-1:0]   preempt_dir,
  output logic [3*N_DIR-1:0] lights,
  output logic [DIR_W-1:0]   cur_dir,
  output logic [1:0]         phase,
  output logic [N_DIR-1:0]   pending
);

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    ALLRED = 2'b10
  } state_t;

  state_t             state, state_n;
  logic [DIR_W-1:0]   dir_n, act_dir, scan;
  logic [CNT_W-1:0]   timer, timer_n;
  logic [N_DIR-1:0]   pending_n, clr_mask;
  logic [3*N_DIR-1:0] lights_n;
  logic               pv, found, any_pend, other_pend;

  function automatic logic [DIR_W-1:0] inc_dir(input logic [DIR_W-1:0] d);
    int n;
    n = int'(d) + 1;
    if (n >= N_DIR) n = 0;
    return DIR_W'(n);
  endfunction

  function automatic logic [N_DIR-1:0] onehot(input logic [DIR_W-1:0] d);
    logic [N_DIR-1:0] m;
    m    = '0;
    m[d] = 1'b1;
    return m;
  endfunction

  function automatic logic [3*N_DIR-1:0] lamp_field(input state_t s, input logic [DIR_W-1:0] d);
    logic [3*N_DIR-1:0] l;
    for (int i = 0; i < N_DIR; i++) begin
      l[3*i +: 3] = 3'b100;
      if (DIR_W'(i) == d && s == GREEN)  l[3*i +: 3] = 3'b001;
      if (DIR_W'(i) == d && s == YELLOW) l[3*i +: 3] = 3'b010;
    end
    return l;
  endfunction

  // Round-robin demand search starting just after the current owner; the owner is checked last.
  always_comb begin
    pv         = preempt && (int'(preempt_dir) < N_DIR);
    any_pend   = |pending;
    other_pend = |(pending & ~onehot(cur_dir));
    act_dir    = inc_dir(cur_dir);
    found      = 1'b0;
    scan       = cur_dir;
    for (int k = 0; k < N_DIR; k++) begin
      scan = inc_dir(scan);
      if (!found && pending[scan]) begin
        found   = 1'b1;
        act_dir = scan;
      end
    end
  end

  always_comb begin
    state_n  = state;
    dir_n    = cur_dir;
    timer_n  = timer - CNT_W'(1);
    clr_mask = '0;
    case (state)
      GREEN: begin
        if (pv && cur_dir != preempt_dir) begin
          state_n = YELLOW;
          timer_n = CNT_W'(YELLOW_T - 1);
        end else if (pv) begin
          timer_n = timer;
        end else if (timer == '0) begin
          if (mode && !other_pend) begin
            timer_n = CNT_W'(GREEN_T - 1);
          end else begin
            state_n = YELLOW;
            timer_n = CNT_W'(YELLOW_T - 1);
          end
        end
      end
      YELLOW: begin
        if (timer == '0) begin
          state_n = ALLRED;
          timer_n = CNT_W'(ALLRED_T - 1);
        end
      end
      default: begin
        if (timer == '0) begin
          if (pv || !mode || any_pend) begin
            state_n  = GREEN;
            timer_n  = CNT_W'(GREEN_T - 1);
            dir_n    = pv ? preempt_dir : (!mode ? inc_dir(cur_dir) : act_dir);
            clr_mask = onehot(dir_n);
          end else begin
            timer_n = CNT_W'(ALLRED_T - 1);
          end
        end
      end
    endcase
    // Clear wins over a same-cycle request for the direction entering green.
    pending_n = (pending | req) & ~clr_mask;
    lights_n  = lamp_field(state_n, dir_n);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ALLRED;
      cur_dir <= DIR_W'(N_DIR - 1);
      timer   <= CNT_W'(ALLRED_T - 1);
      pending <= '0;
      lights  <= {N_DIR{3'b100}};
    end else begin
      state   <= state_n;
      cur_dir <= dir_n;
      timer   <= timer_n;
      pending <= pending_n;
      lights  <= lights_n;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_light_controller_n.sv
// Directed bench for traffic_light_controller_n: a 4-direction instance for the main scenarios
// and a 6-direction instance where an out-of-range preempt_dir can be expressed.
module tb_traffic_light_controller_n;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode = 1'b0;
  logic [3:0]  req = '0;
  logic        preempt = 1'b0;
  logic [1:0]  preempt_dir = '0;
  logic [11:0] lights;
  logic [1:0]  cur_dir;
  logic [1:0]  phase;
  logic [3:0]  pending;

  logic        preempt6 = 1'b1;
  logic [2:0]  preempt_dir6 = 3'd6;
  logic [5:0]  req6 = '0;
  logic [17:0] lights6;
  logic [2:0]  cur_dir6;
  logic [1:0]  phase6;
  logic [5:0]  pending6;

  int checks = 0;
  int errors = 0;

  logic        do_chk;
  logic [1:0]  e_ph;
  logic [2:0]  e_dir;
  logic [17:0] e_l;

  always #5 clk = ~clk;

  traffic_light_controller_n #(.N_DIR(4), .CNT_W(8), .GREEN_T(15), .YELLOW_T(3), .ALLRED_T(3)) u_dut (
    .clk(clk), .reset(reset), .mode(mode), .req(req), .preempt(preempt), .preempt_dir(preempt_dir),
    .lights(lights), .cur_dir(cur_dir), .phase(phase), .pending(pending)
  );

  traffic_light_controller_n #(.N_DIR(6), .CNT_W(8), .GREEN_T(4), .YELLOW_T(2), .ALLRED_T(1)) u_dut6 (
    .clk(clk), .reset(reset), .mode(1'b0), .req(req6), .preempt(preempt6), .preempt_dir(preempt_dir6),
    .lights(lights6), .cur_dir(cur_dir6), .phase(phase6), .pending(pending6)
  );

  task automatic do_reset(input logic m);
    mode = m; req = '0; preempt = 1'b0; preempt_dir = '0;
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    mode = 1'b0; req = '0; preempt = 1'b0;
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (lights !== 12'h924 || phase !== 2'b10) begin
      $display("FAIL reset_lamps: lights=%h phase=%b, want lights=924 phase=10", lights, phase); errors++;
    end
    checks++;
    if (cur_dir !== 2'd3 || pending !== 4'b0000) begin
      $display("FAIL reset_state: cur_dir=%0d pending=%b, want cur_dir=3 pending=0000", cur_dir, pending); errors++;
    end
    reset = 1'b0;
  endtask

  task automatic test_fixed;
    for (int c = 1; c <= 87; c++) begin
      @(negedge clk);
      do_chk = 1'b1;
      case (c)
        2:       begin e_ph = 2'b10; e_dir = 3'd3; e_l = 18'h924; end
        3:       begin e_ph = 2'b00; e_dir = 3'd0; e_l = 18'h921; end
        17:      begin e_ph = 2'b00; e_dir = 3'd0; e_l = 18'h921; end
        18:      begin e_ph = 2'b01; e_dir = 3'd0; e_l = 18'h922; end
        20:      begin e_ph = 2'b01; e_dir = 3'd0; e_l = 18'h922; end
        21:      begin e_ph = 2'b10; e_dir = 3'd0; e_l = 18'h924; end
        23:      begin e_ph = 2'b10; e_dir = 3'd0; e_l = 18'h924; end
        24:      begin e_ph = 2'b00; e_dir = 3'd1; e_l = 18'h90C; end
        86:      begin e_ph = 2'b10; e_dir = 3'd3; e_l = 18'h924; end
        87:      begin e_ph = 2'b00; e_dir = 3'd0; e_l = 18'h921; end
        default: begin do_chk = 1'b0; e_ph = 2'b00; e_dir = 3'd0; e_l = '0; end
      endcase
      if (do_chk) begin
        checks++;
        if (phase !== e_ph || {1'b0, cur_dir} !== e_dir || lights !== e_l[11:0]) begin
          $display("FAIL fixed_c%0d: phase=%b dir=%0d lights=%h, want phase=%b dir=%0d lights=%h",
                   c, phase, cur_dir, lights, e_ph, e_dir, e_l[11:0]);
          errors++;
        end
      end
    end
  endtask

  task automatic test_actuated_single;
    do_reset(1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if (phase !== 2'b10 || cur_dir !== 2'd3 || pending !== 4'b0000) begin
      $display("FAIL act_rest_allred: phase=%b dir=%0d pending=%b, want 10 3 0000", phase, cur_dir, pending); errors++;
    end
    req = 4'b0100;
    @(negedge clk) req = '0;
    checks++;
    if (pending !== 4'b0100 || phase !== 2'b10) begin
      $display("FAIL act_req_latch: pending=%b phase=%b, want 0100 10", pending, phase); errors++;
    end
    @(negedge clk);
    checks++;
    if (phase !== 2'b00 || cur_dir !== 2'd2 || pending !== 4'b0000 || lights !== 12'h864) begin
      $display("FAIL act_green2: phase=%b dir=%0d pending=%b lights=%h, want 00 2 0000 864",
               phase, cur_dir, pending, lights); errors++;
    end
    repeat (48) @(negedge clk);
    checks++;
    if (phase !== 2'b00 || cur_dir !== 2'd2 || lights !== 12'h864) begin
      $display("FAIL act_green_rest: phase=%b dir=%0d lights=%h, want 00 2 864", phase, cur_dir, lights); errors++;
    end
  endtask

  task automatic test_actuated_order;
    do_reset(1'b1);
    req = 4'b0001;
    @(negedge clk) req = '0;
    checks++;
    if (pending !== 4'b0001) begin
      $display("FAIL ord_pend0: pending=%b, want 0001", pending); errors++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (phase !== 2'b00 || cur_dir !== 2'd0 || pending !== 4'b0000) begin
      $display("FAIL ord_green0: phase=%b dir=%0d pending=%b, want 00 0 0000", phase, cur_dir, pending); errors++;
    end
    @(negedge clk) req = 4'b1010;
    @(negedge clk) req = '0;
    checks++;
    if (pending !== 4'b1010) begin
      $display("FAIL ord_pend1010: pending=%b, want 1010", pending); errors++;
    end
    repeat (13) @(negedge clk);
    checks++;
    if (phase !== 2'b01 || cur_dir !== 2'd0) begin
      $display("FAIL ord_yellow0: phase=%b dir=%0d, want 01 0", phase, cur_dir); errors++;
    end
    repeat (5) @(negedge clk);
    req = 4'b0010;
    @(negedge clk) req = '0;
    checks++;
    if (phase !== 2'b00 || cur_dir !== 2'd1 || pending !== 4'b1000) begin
      $display("FAIL ord_green1: phase=%b dir=%0d pending=%b, want 00 1 1000", phase, cur_dir, pending); errors++;
    end
    repeat (20) @(negedge clk);
    checks++;
    if (phase !== 2'b10 || cur_dir !== 2'd1) begin
      $display("FAIL ord_allred1: phase=%b dir=%0d, want 10 1", phase, cur_dir); errors++;
    end
    @(negedge clk);
    checks++;
    if (phase !== 2'b00 || cur_dir !== 2'd3 || pending !== 4'b0000) begin
      $display("FAIL ord_green3: phase=%b dir=%0d pending=%b, want 00 3 0000", phase, cur_dir, pending); errors++;
    end
  endtask

  task automatic test_preempt;
    do_reset(1'b0);
    repeat (7) @(negedge clk);
    checks++;
    if (phase !== 2'b00 || cur_dir !== 2'd0) begin
      $display("FAIL pre_green0: phase=%b dir=%0d, want 00 0", phase, cur_dir); errors++;
    end
    preempt = 1'b1; preempt_dir = 2'd3;
    @(negedge clk);
    checks++;
    if (phase !== 2'b01 || cur_dir !== 2'd0 || lights !== 12'h922) begin
      $display("FAIL pre_yellow: phase=%b dir=%0d lights=%h, want 01 0 922", phase, cur_dir, lights); errors++;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (phase !== 2'b10 || cur_dir !== 2'd0) begin
      $display("FAIL pre_allred: phase=%b dir=%0d, want 10 0", phase, cur_dir); errors++;
    end
    @(negedge clk);
    checks++;
    if (phase !== 2'b00 || cur_dir !== 2'd3 || lights !== 12'h324) begin
      $display("FAIL pre_green3: phase=%b dir=%0d lights=%h, want 00 3 324", phase, cur_dir, lights); errors++;
    end
    repeat (50) @(negedge clk);
    checks++;
    if (phase !== 2'b00 || cur_dir !== 2'd3) begin
      $display("FAIL pre_hold: phase=%b dir=%0d, want 00 3", phase, cur_dir); errors++;
    end
    preempt = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (phase !== 2'b00 || cur_dir !== 2'd3) begin
      $display("FAIL pre_resume_green: phase=%b dir=%0d, want 00 3", phase, cur_dir); errors++;
    end
    @(negedge clk);
    checks++;
    if (phase !== 2'b01 || cur_dir !== 2'd3) begin
      $display("FAIL pre_resume_yellow: phase=%b dir=%0d, want 01 3", phase, cur_dir); errors++;
    end
    repeat (6) @(negedge clk);
    checks++;
    if (phase !== 2'b00 || cur_dir !== 2'd0 || lights !== 12'h921) begin
      $display("FAIL pre_next_green0: phase=%b dir=%0d lights=%h, want 00 0 921", phase, cur_dir, lights); errors++;
    end
  endtask

  task automatic test_preempt_invalid;
    do_reset(1'b0);
    for (int c = 1; c <= 43; c++) begin
      @(negedge clk);
      do_chk = 1'b1;
      case (c)
        1, 4:    begin e_ph = 2'b00; e_dir = 3'd0; end
        5:       begin e_ph = 2'b01; e_dir = 3'd0; end
        7:       begin e_ph = 2'b10; e_dir = 3'd0; end
        8:       begin e_ph = 2'b00; e_dir = 3'd1; end
        15:      begin e_ph = 2'b00; e_dir = 3'd2; end
        36:      begin e_ph = 2'b00; e_dir = 3'd5; end
        43:      begin e_ph = 2'b00; e_dir = 3'd0; end
        default: begin do_chk = 1'b0; e_ph = 2'b00; e_dir = 3'd0; end
      endcase
      if (do_chk) begin
        checks++;
        if (phase6 !== e_ph || cur_dir6 !== e_dir) begin
          $display("FAIL inv_pre_c%0d: phase=%b dir=%0d, want phase=%b dir=%0d", c, phase6, cur_dir6, e_ph, e_dir);
          errors++;
        end
      end
      if (c == 8) begin
        checks++;
        if (lights6 !== 18'h2490C || pending6 !== 6'b000000) begin
          $display("FAIL inv_pre_lamps: lights=%h pending=%b, want 2490c 000000", lights6, pending6); errors++;
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset(1'b0);
    repeat (30) @(negedge clk);
    req = 4'b0101;
    @(negedge clk) req = '0;
    repeat (9) @(negedge clk);
    checks++;
    if (phase !== 2'b01 || cur_dir !== 2'd1 || pending !== 4'b0101) begin
      $display("FAIL mid_yellow1: phase=%b dir=%0d pending=%b, want 01 1 0101", phase, cur_dir, pending); errors++;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (phase !== 2'b10 || cur_dir !== 2'd3 || pending !== 4'b0000 || lights !== 12'h924) begin
      $display("FAIL mid_async_reset: phase=%b dir=%0d pending=%b lights=%h, want 10 3 0000 924",
               phase, cur_dir, pending, lights); errors++;
    end
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (phase !== 2'b00 || cur_dir !== 2'd0 || lights !== 12'h921) begin
      $display("FAIL mid_restart_green: phase=%b dir=%0d lights=%h, want 00 0 921", phase, cur_dir, lights); errors++;
    end
    repeat (15) @(negedge clk);
    checks++;
    if (phase !== 2'b01 || cur_dir !== 2'd0) begin
      $display("FAIL mid_restart_yellow: phase=%b dir=%0d, want 01 0", phase, cur_dir); errors++;
    end
  endtask

  initial begin
    test_reset;
    test_fixed;
    test_actuated_single;
    test_actuated_order;
    test_preempt;
    test_preempt_invalid;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
